// File: rtl/adder_8bit_seq_ctrl.sv
// Wide unsigned adder that reuses a single 8-bit add slice, one byte per clock.
// Optional signed-overflow output enabled by defining ADDSEQ_OVF_EN.
module adder_8bit_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
`ifdef ADDSEQ_OVF_EN
  output logic                  ovf,
`endif
  output logic                  busy
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             init_q;
`ifdef ADDSEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [7:0] a_byte, b_byte;
  logic [8:0] add_res;
  logic       accept;

  // init_q keeps start_ready low until the first edge after reset release.
  assign start_ready = init_q && (state_q == IDLE);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;
`ifdef ADDSEQ_OVF_EN
  assign ovf         = ovf_q;
`endif

  assign accept  = start_valid && start_ready;
  assign a_byte  = a_q[8*int'(idx_q) +: 8];
  assign b_byte  = b_q[8*int'(idx_q) +: 8];
  assign add_res = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDSEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[8*int'(idx_q) +: 8] = add_res[7:0];
        carry_d = add_res[8];
        if (idx_q == LAST_IDX) begin
          cout_d  = add_res[8];
`ifdef ADDSEQ_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit and its operands.
          ovf_d   = (a_byte[7] ^ b_byte[7] ^ add_res[7]) ^ add_res[8];
`endif
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      init_q  <= 1'b0;
`ifdef ADDSEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      init_q  <= 1'b1;
`ifdef ADDSEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_adder_8bit_seq_ctrl.sv
// Bench for adder_8bit_seq_ctrl: a 4-byte and a 1-byte instance on a shared clock/reset.
module tb_adder_8bit_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sv4, sr4, rv4, rr4, cin4, co4, bz4;
  logic [31:0] a4, b4, s4;
  logic        sv1, sr1, rv1, rr1, cin1, co1, bz1;
  logic [7:0]  a1, b1, s1;
`ifdef ADDSEQ_OVF_EN
  logic        ov4, ov1;
`endif

  adder_8bit_seq_ctrl #(.NBYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .cin(cin4), .res_valid(rv4), .res_ready(rr4),
    .sum(s4), .cout(co4),
`ifdef ADDSEQ_OVF_EN
    .ovf(ov4),
`endif
    .busy(bz4));

  adder_8bit_seq_ctrl #(.NBYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a(a1), .b(b1), .cin(cin1), .res_valid(rv1), .res_ready(rr1),
    .sum(s1), .cout(co1),
`ifdef ADDSEQ_OVF_EN
    .ovf(ov1),
`endif
    .busy(bz1));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run4(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                      input int hold, input logic [31:0] es, input logic ec,
                      input logic eo, input string nm);
    int n;
    a4 = ta; b4 = tb; cin4 = tc; sv4 = 1'b1; rr4 = (hold == 0);
    n = 0;
    while (!sr4 && n < 20) begin tick(); n++; end
    check({nm, " start_ready"}, 64'(sr4), 64'd1);
    tick();
    sv4 = 1'b0; a4 = $urandom; b4 = $urandom; cin4 = 1'($urandom);
    n = 0;
    while (!rv4 && n < 20) begin tick(); n++; end
    check({nm, " latency"}, 64'(n), 64'd4);
    check({nm, " sum"}, 64'(s4), 64'(es));
    check({nm, " cout"}, 64'(co4), 64'(ec));
`ifdef ADDSEQ_OVF_EN
    check({nm, " ovf"}, 64'(ov4), 64'(eo));
`else
    if (eo === 1'bx) $display("unexpected X in expected ovf");
`endif
    for (int i = 0; i < hold; i++) begin
      sv4 = ~sv4; a4 = $urandom; b4 = $urandom;
      tick();
      check({nm, " hold res_valid"}, 64'(rv4), 64'd1);
      check({nm, " hold start_ready"}, 64'(sr4), 64'd0);
      check({nm, " hold sum"}, 64'(s4), 64'(es));
      check({nm, " hold cout"}, 64'(co4), 64'(ec));
    end
    rr4 = 1'b1;
    if (hold > 0) tick();
    else begin
      check({nm, " busy in DONE"}, 64'(bz4), 64'd1);
      tick();
    end
    sv4 = 1'b0;
    check({nm, " res_valid after hs"}, 64'(rv4), 64'd0);
    check({nm, " start_ready after hs"}, 64'(sr4), 64'd1);
    check({nm, " idle after hs"}, 64'(bz4), 64'd0);
  endtask

  task automatic run1(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input string nm);
    int n;
    logic [8:0] ref_v;
    ref_v = {1'b0, ta} + {1'b0, tb} + {8'd0, tc};
    a1 = ta; b1 = tb; cin1 = tc; sv1 = 1'b1; rr1 = 1'b1;
    n = 0;
    while (!sr1 && n < 20) begin tick(); n++; end
    tick();
    sv1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    n = 0;
    while (!rv1 && n < 20) begin tick(); n++; end
    check({nm, " latency"}, 64'(n), 64'd1);
    check({nm, " sum"}, 64'(s1), 64'(ref_v[7:0]));
    check({nm, " cout"}, 64'(co1), 64'(ref_v[8]));
`ifdef ADDSEQ_OVF_EN
    check({nm, " ovf"}, 64'(ov1), 64'((ta[7] == tb[7]) && (ref_v[7] != ta[7])));
`endif
    tick();
    check({nm, " start_ready after hs"}, 64'(sr1), 64'd1);
  endtask

  initial begin
    logic [32:0] r33;
    logic [31:0] ra, rb;
    logic        rc;

    vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0};
    vt[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vt[2] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0};
    vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
    vt[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vt[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vt[6] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};

    rst_n = 1'b0;
    sv4 = 0; rr4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    sv1 = 0; rr1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #12;
    check("rst start_ready", 64'(sr4), 64'd0);
    check("rst res_valid", 64'(rv4), 64'd0);
    check("rst busy", 64'(bz4), 64'd0);
    check("rst sum", 64'(s4), 64'd0);
    check("rst cout", 64'(co4), 64'd0);
    check("rst start_ready n1", 64'(sr1), 64'd0);
    #1 rst_n = 1'b1;
    #1 check("start_ready before first edge", 64'(sr4), 64'd0);
    tick();
    check("start_ready after first edge", 64'(sr4), 64'd1);
    check("start_ready after first edge n1", 64'(sr1), 64'd1);

    for (int i = 0; i < 7; i++)
      run4(vt[i].a, vt[i].b, vt[i].cin, (i == 2) ? 5 : 0,
           vt[i].s, vt[i].co, vt[i].ov, $sformatf("vec%0d", i));

    // Abort after two RUN cycles, then rerun the same operands cleanly.
    a4 = 32'h12345678; b4 = 32'h11111111; cin4 = 1'b0; sv4 = 1'b1; rr4 = 1'b1;
    tick();
    sv4 = 1'b0;
    tick();
    tick();
    check("midrun busy", 64'(bz4), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort sum", 64'(s4), 64'd0);
    check("abort cout", 64'(co4), 64'd0);
    check("abort res_valid", 64'(rv4), 64'd0);
    check("abort busy", 64'(bz4), 64'd0);
    check("abort start_ready", 64'(sr4), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    run4(32'h12345678, 32'h11111111, 1'b0, 0, 32'h23456789, 1'b0, 1'b0, "post_abort");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      if (i == 0) begin ra = 32'hFFFFFFFF; rb = 32'h1; end
      r33 = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      run4(ra, rb, rc, (i % 10 == 3) ? 2 : 0, r33[31:0], r33[32],
           (ra[31] == rb[31]) && (r33[31] != ra[31]), $sformatf("rnd4_%0d", i));
    end

    run1(8'hC8, 8'h64, 1'b1, "n1_hand");
    check("n1_hand sum const", 64'(s1), 64'h2D);
    for (int i = 0; i < 100; i++)
      run1(8'($urandom), 8'($urandom), 1'($urandom), $sformatf("rnd1_%0d", i));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
